// File: rtl/axis_gmii_pkg.sv
// Shared types and constants for the AXI-Stream to GMII serializer.
package axis_gmii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ABORT,
    GAP
  } tx_state_e;

  localparam logic [7:0]  TXD_IDLE = 8'h00;
  localparam int unsigned CNT_W    = 16;

endpackage

// File: rtl/axis_word_fifo.sv
// Synchronous show-ahead word FIFO with occupancy count.
module axis_word_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_gmii_serializer.sv
// Buffers AXI-Stream words and serialises frames LSB-byte-first onto GMII,
// with start threshold, inter-frame gap and underrun abort.
module axis_gmii_serializer #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned START_THRESH = 2,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic                gmii_tx_clk,
  input  logic                rst_n,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  output logic                gmii_tx_en,
  output logic                gmii_tx_er,
  output logic [7:0]          gmii_txd,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         underrun_cnt
);

  import axis_gmii_pkg::*;

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned FW    = DATA_W + BYTES + 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned GAP_N = (IFG_BYTES == 0) ? 1 : IFG_BYTES;

  localparam logic [AW:0]   THRESH   = (AW+1)'(START_THRESH);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP_N - 1);
  localparam logic [BW-1:0] IDX_MAX  = BW'(BYTES - 1);

  tx_state_e         state, state_d;
  logic              rdy_q;
  logic              push, pop, load;
  logic [FW-1:0]     f_rd;
  logic [DATA_W-1:0] f_data;
  logic [BYTES-1:0]  f_keep;
  logic              f_last;
  logic [AW:0]       count;
  logic              full, empty;
  logic [AW:0]       frames_q;
  logic              start_ok;

  logic [DATA_W-1:0] sh_data;
  logic              sh_last;
  logic [BW-1:0]     last_idx, head_last_idx;
  logic [BW-1:0]     byte_idx, idx_d;
  logic [7:0]        gap_cnt, gap_d;
  logic              ab_first, ab_first_d;
  logic              en_d, er_d;
  logic [7:0]        txd_d;
  logic              fcnt_inc, urun_inc;

  assign s_axis_tready = rdy_q & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign {f_data, f_keep, f_last} = f_rd;
  assign busy          = (state != IDLE);
  assign start_ok      = (count >= THRESH) || (frames_q != '0);

  axis_word_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (gmii_tx_clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .rd_en   (pop),
    .rd_data (f_rd),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Highest enabled byte of the head word; an all-zero keep still sends byte 0.
  always_comb begin
    head_last_idx = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (f_keep[b]) head_last_idx = BW'(b);
    end
  end

  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    load       = 1'b0;
    idx_d      = byte_idx;
    gap_d      = gap_cnt;
    ab_first_d = 1'b0;
    en_d       = 1'b0;
    er_d       = 1'b0;
    txd_d      = TXD_IDLE;
    fcnt_inc   = 1'b0;
    urun_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        en_d  = 1'b1;
        txd_d = sh_data[{byte_idx, 3'b000} +: 8];
        if (byte_idx != last_idx) begin
          idx_d = byte_idx + 1'b1;
        end else if (sh_last) begin
          fcnt_inc = 1'b1;
          gap_d    = GAP_LOAD;
          state_d  = GAP;
        end else if (!empty) begin
          pop  = 1'b1;
          load = 1'b1;
        end else begin
          ab_first_d = 1'b1;
          state_d    = ABORT;
        end
      end
      ABORT: begin
        // The error symbol goes out on the first abort cycle only, directly
        // after the last good byte.
        if (ab_first) begin
          en_d     = 1'b1;
          er_d     = 1'b1;
          urun_inc = 1'b1;
        end
        if (!empty) begin
          pop = 1'b1;
          if (f_last) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_d = gap_cnt - 1'b1;
        end else if (start_ok) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) idx_d = '0;
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      frames_q     <= '0;
      sh_data      <= '0;
      sh_last      <= 1'b0;
      last_idx     <= '0;
      byte_idx     <= '0;
      gap_cnt      <= '0;
      ab_first     <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_tx_er   <= 1'b0;
      gmii_txd     <= TXD_IDLE;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_d;
      rdy_q    <= 1'b1;
      byte_idx <= idx_d;
      gap_cnt  <= gap_d;
      ab_first <= ab_first_d;
      case ({push & s_axis_tlast, pop & f_last})
        2'b10:   frames_q <= frames_q + 1'b1;
        2'b01:   frames_q <= frames_q - 1'b1;
        default: frames_q <= frames_q;
      endcase
      if (load) begin
        sh_data  <= f_data;
        sh_last  <= f_last;
        last_idx <= f_last ? head_last_idx : IDX_MAX;
      end
      gmii_tx_en <= en_d;
      gmii_tx_er <= er_d;
      gmii_txd   <= txd_d;
      if (fcnt_inc) frame_cnt <= frame_cnt + 1'b1;
      if (urun_inc && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_gmii_serializer.sv
// Directed bench: dut_a (DEPTH 8, IFG 12) and dut_b (DEPTH 4, IFG 0), selected by sel.
module tb_axis_gmii_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  logic        rdy_a, en_a, er_a, busy_a;
  logic [7:0]  txd_a;
  logic [15:0] fc_a, uc_a;
  logic        rdy_b, en_b, er_b, busy_b;
  logic [7:0]  txd_b;
  logic [15:0] fc_b, uc_b;

  logic        tready, ten, ter, tbusy;
  logic [7:0]  ttxd;
  logic [15:0] fcnt, ucnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int unsigned burst_q[$];
  int unsigned gap_q[$];
  int unsigned burst    = 0;
  int unsigned idle_run = 0;
  logic        seen     = 1'b0;
  int unsigned er_n     = 0;
  logic        bp_seen  = 1'b0;

  int unsigned rb, bb, gb;

  always #5 clk = ~clk;

  axis_gmii_serializer #(
    .DATA_W(64), .DEPTH(8), .START_THRESH(2), .IFG_BYTES(12)
  ) dut_a (
    .gmii_tx_clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(rdy_a),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .gmii_tx_en(en_a), .gmii_tx_er(er_a), .gmii_txd(txd_a),
    .busy(busy_a), .frame_cnt(fc_a), .underrun_cnt(uc_a)
  );

  axis_gmii_serializer #(
    .DATA_W(64), .DEPTH(4), .START_THRESH(2), .IFG_BYTES(0)
  ) dut_b (
    .gmii_tx_clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(tvalid & sel), .s_axis_tready(rdy_b),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .gmii_tx_en(en_b), .gmii_tx_er(er_b), .gmii_txd(txd_b),
    .busy(busy_b), .frame_cnt(fc_b), .underrun_cnt(uc_b)
  );

  assign tready = sel ? rdy_b  : rdy_a;
  assign ten    = sel ? en_b   : en_a;
  assign ter    = sel ? er_b   : er_a;
  assign ttxd   = sel ? txd_b  : txd_a;
  assign tbusy  = sel ? busy_b : busy_a;
  assign fcnt   = sel ? fc_b   : fc_a;
  assign ucnt   = sel ? uc_b   : uc_a;

  always @(negedge clk) begin
    if (ten) begin
      if (seen && idle_run > 0) gap_q.push_back(idle_run);
      idle_run <= 0;
      burst    <= burst + 1;
      seen     <= 1'b1;
      rx_q.push_back(ttxd);
      if (ter) er_n <= er_n + 1;
    end else begin
      if (burst > 0) burst_q.push_back(burst);
      burst    <= 0;
      idle_run <= idle_run + 1;
    end
    if (sel && tvalid && !tready) bp_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    int unsigned n;
    n = 0;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    while (tready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("push_ready", {31'd0, tready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic stop();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Word byte j = seed + j; expected bytes are queued only for words meant to appear.
  task automatic send_word(input logic [7:0] seed, input logic l, input logic [7:0] k, input logic expect_tx);
    logic [63:0] d;
    int unsigned nb;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = seed + 8'(j);
    nb = 8;
    if (l) begin
      nb = 1;
      for (int j = 0; j < 8; j++) if (k[j]) nb = j + 1;
    end
    if (expect_tx) for (int j = 0; j < nb; j++) exp_q.push_back(seed + 8'(j));
    push(d, k, l);
  endtask

  task automatic wait_frames(input string tag, input logic [15:0] target);
    int unsigned n;
    n = 0;
    while (fcnt !== target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {16'd0, fcnt}, {16'd0, target});
    repeat (3) @(negedge clk);
  endtask

  task automatic check_bytes(input string tag, input int unsigned base);
    logic [31:0] obs;
    chk({tag, "_len"}, rx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < rx_q.size()) ? {24'd0, rx_q[base + i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_b%0d", tag, i), obs, {24'd0, exp_q[i]});
    end
  endtask

  task automatic begin_test();
    exp_q.delete();
    rb = rx_q.size();
    bb = burst_q.size();
    gb = gap_q.size();
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; sel = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready_a", {31'd0, tready}, 32'd0);
    chk("rst_en_a", {31'd0, ten}, 32'd0);
    chk("rst_er_a", {31'd0, ter}, 32'd0);
    chk("rst_txd_a", {24'd0, ttxd}, 32'd0);
    chk("rst_busy_a", {31'd0, tbusy}, 32'd0);
    chk("rst_fcnt_a", {16'd0, fcnt}, 32'd0);
    chk("rst_ucnt_a", {16'd0, ucnt}, 32'd0);
    sel = 1'b1; #1;
    chk("rst_tready_b", {31'd0, tready}, 32'd0);
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", {31'd0, tready}, 32'd1);
    chk("post_rst_en", {31'd0, ten}, 32'd0);

    // Three-word frame, last keep 0x0F: 20 gapless bytes.
    begin_test();
    send_word(8'h10, 1'b0, 8'hFF, 1'b1);
    send_word(8'h20, 1'b0, 8'hFF, 1'b1);
    send_word(8'h30, 1'b1, 8'h0F, 1'b1);
    stop();
    wait_frames("t1_fcnt", 16'd1);
    chk("t1_burst", burst_q[bb], 32'd20);
    check_bytes("t1", rb);

    // Start threshold: a lone non-last word must not start a frame.
    begin_test();
    send_word(8'h40, 1'b0, 8'hFF, 1'b1);
    stop();
    repeat (20) @(negedge clk);
    chk("t2_hold_rx", rx_q.size() - rb, 32'd0);
    chk("t2_hold_busy", {31'd0, tbusy}, 32'd0);
    send_word(8'h50, 1'b1, 8'hFF, 1'b1);
    stop();
    wait_frames("t2_fcnt", 16'd2);
    check_bytes("t2", rb);

    // Two queued frames: 12 idle cycles between them.
    begin_test();
    send_word(8'h60, 1'b0, 8'hFF, 1'b1);
    send_word(8'h70, 1'b1, 8'hFF, 1'b1);
    send_word(8'h80, 1'b0, 8'hFF, 1'b1);
    send_word(8'h90, 1'b1, 8'hFF, 1'b1);
    stop();
    wait_frames("t3_fcnt", 16'd4);
    chk("t3_ngap", gap_q.size() - gb, 32'd2);
    chk("t3_gap", gap_q[gb + 1], 32'd12);
    check_bytes("t3", rb);

    // tlast with tkeep=0 sends exactly one byte.
    begin_test();
    send_word(8'hA0, 1'b0, 8'hFF, 1'b1);
    send_word(8'hB0, 1'b1, 8'h00, 1'b1);
    stop();
    wait_frames("t4_fcnt", 16'd5);
    chk("t4_burst", burst_q[bb], 32'd9);
    check_bytes("t4", rb);

    // Underrun: 16 good bytes then one error symbol; remainder discarded.
    begin_test();
    send_word(8'hC0, 1'b0, 8'hFF, 1'b1);
    send_word(8'hD0, 1'b0, 8'hFF, 1'b1);
    stop();
    exp_q.push_back(8'h00);
    repeat (25) @(negedge clk);
    chk("t5_ucnt", {16'd0, ucnt}, 32'd1);
    chk("t5_er_cycles", er_n, 32'd1);
    chk("t5_burst", burst_q[bb], 32'd17);
    send_word(8'hE0, 1'b0, 8'hFF, 1'b0);
    send_word(8'hF0, 1'b1, 8'hFF, 1'b0);
    stop();
    n = 0;
    while (tbusy && n < 500) begin @(negedge clk); n++; end
    chk("t5_idle", {31'd0, tbusy}, 32'd0);
    chk("t5_fcnt", {16'd0, fcnt}, 32'd5);
    check_bytes("t5", rb);
    begin_test();
    send_word(8'h11, 1'b0, 8'hFF, 1'b1);
    send_word(8'h22, 1'b1, 8'hFF, 1'b1);
    stop();
    wait_frames("t5b_fcnt", 16'd6);
    chk("t5b_ucnt", {16'd0, ucnt}, 32'd1);
    chk("t5b_er_cycles", er_n, 32'd1);
    check_bytes("t5b", rb);

    // dut_b, IFG 0: exactly one idle cycle between queued frames.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    begin_test();
    send_word(8'h31, 1'b0, 8'hFF, 1'b1);
    send_word(8'h41, 1'b1, 8'hFF, 1'b1);
    send_word(8'h51, 1'b0, 8'hFF, 1'b1);
    send_word(8'h61, 1'b1, 8'hFF, 1'b1);
    stop();
    wait_frames("t6_fcnt", 16'd2);
    chk("t6_gap", gap_q[gb + 1], 32'd1);
    check_bytes("t6", rb);

    // Backpressure on DEPTH 4: ten-word frame streams with no loss.
    begin_test();
    for (int w = 0; w < 10; w++)
      send_word(8'(8'h03 + 8'(16 * w)), (w == 9), 8'hFF, 1'b1);
    stop();
    wait_frames("t7_fcnt", 16'd3);
    chk("t7_bp_seen", {31'd0, bp_seen}, 32'd1);
    chk("t7_burst", burst_q[bb], 32'd80);
    check_bytes("t7", rb);

    // Reset mid-SEND clears outputs at once; next frame is clean.
    send_word(8'h77, 1'b0, 8'hFF, 1'b0);
    send_word(8'h88, 1'b1, 8'hFF, 1'b0);
    stop();
    n = 0;
    while (!ten && n < 200) begin @(negedge clk); n++; end
    chk("t8_started", {31'd0, ten}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_en", {31'd0, ten}, 32'd0);
    chk("t8_er", {31'd0, ter}, 32'd0);
    chk("t8_txd", {24'd0, ttxd}, 32'd0);
    chk("t8_busy", {31'd0, tbusy}, 32'd0);
    chk("t8_fcnt", {16'd0, fcnt}, 32'd0);
    chk("t8_tready", {31'd0, tready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_tready_rel", {31'd0, tready}, 32'd1);
    begin_test();
    send_word(8'h9A, 1'b0, 8'hFF, 1'b1);
    send_word(8'hAB, 1'b1, 8'h3F, 1'b1);
    stop();
    wait_frames("t8b_fcnt", 16'd1);
    chk("t8b_burst", burst_q[bb], 32'd14);
    check_bytes("t8b", rb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
